// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-engine types and helpers: message types, payload masks,
// stream pump FSM states and beat-count arithmetic.
package bp_me_pkg;

   localparam int unsigned msg_type_width_gp = 4;
   localparam int unsigned msg_size_width_gp = 3;

   typedef enum logic [3:0] {
      e_mem_msg_rd    = 4'd0,
      e_mem_msg_wr    = 4'd1,
      e_mem_msg_uc_rd = 4'd2,
      e_mem_msg_uc_wr = 4'd3,
      e_mem_msg_pre   = 4'd4,
      e_mem_msg_amo   = 4'd5
   } bp_me_msg_type_e;

   // Commands carry data on writes; responses carry data on reads and AMOs.
   localparam logic [15:0] mem_cmd_payload_mask_gp =
      16'((32'd1 << e_mem_msg_uc_wr) | (32'd1 << e_mem_msg_wr));
   localparam logic [15:0] mem_resp_payload_mask_gp =
      16'((32'd1 << e_mem_msg_rd) | (32'd1 << e_mem_msg_uc_rd) | (32'd1 << e_mem_msg_amo));

   typedef enum logic {
      e_ready  = 1'b0,
      e_stream = 1'b1
   } pump_state_e;

   function automatic logic payload_present(input logic [15:0] mask, input logic [3:0] msg_type);
      return mask[msg_type];
   endfunction

   // Beats needed for a payload of (8 << size) bits, saturated at one full block.
   function automatic int unsigned stream_beats(input logic [2:0] size,
                                                input int unsigned data_width,
                                                input int unsigned block_width);
      int unsigned msg_bits;
      msg_bits = 32'd8 << size;
      if (msg_bits <= data_width) return 32'd1;
      if (msg_bits >= block_width) return block_width / data_width;
      return msg_bits / data_width;
   endfunction

endpackage

// File: rtl/bp_me_stream_wraparound.sv
// Critical-word-first address/beat-index generator: wraps the offset within the
// message-sized window starting from the base address.
module bp_me_stream_wraparound
   import bp_me_pkg::*;
#(
   parameter int unsigned data_width_p  = 64,
   parameter int unsigned block_width_p = 512,
   parameter int unsigned addr_width_p  = 40,
   localparam int unsigned max_beats_lp = block_width_p / data_width_p,
   localparam int unsigned cnt_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1
)(
   input  logic [addr_width_p-1:0] base_addr,
   input  logic [2:0]              size,
   input  logic [cnt_width_lp-1:0] cnt,
   output logic [addr_width_p-1:0] addr,
   output logic [cnt_width_lp-1:0] beat_idx
);

   localparam int unsigned block_bytes_lp    = block_width_p / 8;
   localparam int unsigned lg_block_bytes_lp = $clog2(block_bytes_lp);
   localparam int unsigned beat_bytes_lp     = data_width_p / 8;
   localparam int unsigned lg_beat_bytes_lp  = $clog2(beat_bytes_lp);

   logic [2:0]                   eff_size;
   logic [lg_block_bytes_lp-1:0] off_mask;
   logic [lg_block_bytes_lp-1:0] base_off;
   logic [lg_block_bytes_lp-1:0] step;
   logic [lg_block_bytes_lp-1:0] offset;
   logic [cnt_width_lp-1:0]      base_beat;
   logic [cnt_width_lp-1:0]      beat_mask;

   // Sizes beyond one block wrap within the block.
   always_comb begin
      eff_size  = (32'(size) > lg_block_bytes_lp) ? 3'(lg_block_bytes_lp) : size;
      off_mask  = lg_block_bytes_lp'((32'd1 << eff_size) - 32'd1);
      base_off  = base_addr[lg_block_bytes_lp-1:0];
      step      = lg_block_bytes_lp'(32'(cnt) << lg_beat_bytes_lp);
      offset    = (base_off + step) & off_mask;
      addr      = {base_addr[addr_width_p-1:lg_block_bytes_lp], (base_off & ~off_mask) | offset};
      base_beat = cnt_width_lp'(base_off >> lg_beat_bytes_lp);
      beat_mask = cnt_width_lp'(off_mask >> lg_beat_bytes_lp);
      beat_idx  = (base_beat + cnt) & beat_mask;
   end

endmodule

// File: rtl/bp_me_bedrock_stream_pump_out.sv
// Converts one BedRock header+payload message into a valid/ready beat stream.
// Optional zero-latency single-beat path enabled by BP_ME_STREAM_PUMP_BYPASS_EN.
module bp_me_bedrock_stream_pump_out
   import bp_me_pkg::*;
#(
   parameter int unsigned data_width_p   = 64,
   parameter int unsigned block_width_p  = 512,
   parameter int unsigned header_width_p = 128,
   parameter int unsigned addr_width_p   = 40,
   parameter logic [15:0] payload_mask_p = mem_cmd_payload_mask_gp
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [header_width_p-1:0] in_header_i,
   input  logic [3:0]                in_msg_type_i,
   input  logic [2:0]                in_size_i,
   input  logic [addr_width_p-1:0]   in_addr_i,
   input  logic [block_width_p-1:0]  in_data_i,
   input  logic                      in_v_i,
   output logic                      in_ready_and_o,
   output logic [header_width_p-1:0] out_header_o,
   output logic [addr_width_p-1:0]   out_addr_o,
   output logic [data_width_p-1:0]   out_data_o,
   output logic                      out_v_o,
   input  logic                      out_ready_and_i,
   output logic                      out_first_o,
   output logic                      out_last_o
);

   localparam int unsigned max_beats_lp     = block_width_p / data_width_p;
   localparam int unsigned cnt_width_lp     = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
   localparam int unsigned beat_bytes_lp    = data_width_p / 8;
   localparam int unsigned lg_beat_bytes_lp = $clog2(beat_bytes_lp);
`ifdef BP_ME_STREAM_PUMP_BYPASS_EN
   localparam bit bypass_en_lp = 1'b1;
`else
   localparam bit bypass_en_lp = 1'b0;
`endif

   pump_state_e               state_r, state_n;
   logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
   logic [cnt_width_lp-1:0]   last_r;
   logic [header_width_p-1:0] header_r;
   logic [addr_width_p-1:0]   addr_r;
   logic [2:0]                size_r;
   logic                      payload_r;
   logic [block_width_p-1:0]  data_r;

   logic                      in_payload_c;
   logic [cnt_width_lp-1:0]   in_last_c;
   logic                      bypass_c;
   logic                      latch_c;
   logic                      in_ready_c;
   logic                      out_v_c;
   logic                      first_c;
   logic                      last_c;

   logic [header_width_p-1:0] src_header;
   logic [addr_width_p-1:0]   src_addr;
   logic [2:0]                src_size;
   logic                      src_payload;
   logic [block_width_p-1:0]  src_data;

   logic [addr_width_p-1:0]     wrap_addr;
   logic [cnt_width_lp-1:0]     beat_idx;
   logic [data_width_p-1:0]     beat_data;
   logic [data_width_p-1:0]     rep_data;
   logic [data_width_p-1:0]     out_data_c;
   logic [lg_beat_bytes_lp-1:0] byte_mask;
   logic [lg_beat_bytes_lp-1:0] byte_sel;

   // Incoming message classification
   always_comb begin
      in_payload_c = payload_present(payload_mask_p, in_msg_type_i);
      in_last_c    = in_payload_c
                   ? cnt_width_lp'(stream_beats(in_size_i, data_width_p, block_width_p) - 32'd1)
                   : '0;
      bypass_c     = bypass_en_lp && (state_r == e_ready) && (in_last_c == '0);
   end

   // Beat source: live inputs on the bypass path, latched message otherwise
   always_comb begin
      src_header  = bypass_c ? in_header_i  : header_r;
      src_addr    = bypass_c ? in_addr_i    : addr_r;
      src_size    = bypass_c ? in_size_i    : size_r;
      src_payload = bypass_c ? in_payload_c : payload_r;
      src_data    = bypass_c ? in_data_i    : data_r;
   end

   bp_me_stream_wraparound #(
      .data_width_p  (data_width_p),
      .block_width_p (block_width_p),
      .addr_width_p  (addr_width_p)
   ) wrap (
      .base_addr (src_addr),
      .size      (src_size),
      .cnt       (cnt_r),
      .addr      (wrap_addr),
      .beat_idx  (beat_idx)
   );

   // Sub-beat payloads are replicated across the whole beat
   always_comb begin
      beat_data = src_data[beat_idx*data_width_p +: data_width_p];
      byte_mask = lg_beat_bytes_lp'((32'd1 << src_size) - 32'd1);
      byte_sel  = '0;
      rep_data  = '0;
      for (int unsigned b = 0; b < beat_bytes_lp; b++) begin
         byte_sel = lg_beat_bytes_lp'(b) & byte_mask;
         rep_data[b*8 +: 8] = beat_data[byte_sel*8 +: 8];
      end
      if (!src_payload)
         out_data_c = '0;
      else if (32'(src_size) < lg_beat_bytes_lp)
         out_data_c = rep_data;
      else
         out_data_c = beat_data;
   end

   // Next-state and handshake logic
   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      latch_c    = 1'b0;
      in_ready_c = 1'b0;
      out_v_c    = 1'b0;
      first_c    = 1'b0;
      last_c     = 1'b0;
      case (state_r)
         e_ready: begin
            if (bypass_c) begin
               in_ready_c = out_ready_and_i;
               out_v_c    = in_v_i & ~reset_i;
               first_c    = in_v_i;
               last_c     = in_v_i;
            end else begin
               in_ready_c = 1'b1;
               if (in_v_i) begin
                  latch_c = 1'b1;
                  cnt_n   = '0;
                  state_n = e_stream;
               end
            end
         end
         e_stream: begin
            out_v_c = 1'b1;
            first_c = (cnt_r == '0);
            last_c  = (cnt_r == last_r);
            if (out_ready_and_i) begin
               if (last_c) begin
                  in_ready_c = 1'b1;
                  cnt_n      = '0;
                  if (in_v_i) latch_c = 1'b1;
                  else        state_n = e_ready;
               end else begin
                  cnt_n = cnt_r + 1'b1;
               end
            end
         end
         default: state_n = e_ready;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r   <= e_ready;
         cnt_r     <= '0;
         last_r    <= '0;
         header_r  <= '0;
         addr_r    <= '0;
         size_r    <= '0;
         payload_r <= 1'b0;
         data_r    <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         if (latch_c) begin
            last_r    <= in_last_c;
            header_r  <= in_header_i;
            addr_r    <= in_addr_i;
            size_r    <= in_size_i;
            payload_r <= in_payload_c;
            data_r    <= in_payload_c ? in_data_i : '0;
         end
      end
   end

   assign in_ready_and_o = in_ready_c & ~reset_i;
   assign out_v_o        = out_v_c;
   assign out_first_o    = first_c;
   assign out_last_o     = last_c;
   assign out_header_o   = src_header;
   assign out_addr_o     = wrap_addr;
   assign out_data_o     = out_data_c;

endmodule

// File: tb/tb_bp_me_bedrock_stream_pump_out.sv
// Directed bench for the BedRock output stream pump (64-bit beats, 512-bit blocks).
module tb_bp_me_bedrock_stream_pump_out;
   import bp_me_pkg::*;

   logic         clk = 1'b0;
   logic         reset_i;
   logic [127:0] in_header_i;
   logic [3:0]   in_msg_type_i;
   logic [2:0]   in_size_i;
   logic [39:0]  in_addr_i;
   logic [511:0] in_data_i;
   logic         in_v_i;
   logic         in_ready_and_o;
   logic [127:0] out_header_o;
   logic [39:0]  out_addr_o;
   logic [63:0]  out_data_o;
   logic         out_v_o;
   logic         out_ready_and_i;
   logic         out_first_o;
   logic         out_last_o;

   always #5 clk = ~clk;

   bp_me_bedrock_stream_pump_out dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .in_header_i     (in_header_i),
      .in_msg_type_i   (in_msg_type_i),
      .in_size_i       (in_size_i),
      .in_addr_i       (in_addr_i),
      .in_data_i       (in_data_i),
      .in_v_i          (in_v_i),
      .in_ready_and_o  (in_ready_and_o),
      .out_header_o    (out_header_o),
      .out_addr_o      (out_addr_o),
      .out_data_o      (out_data_o),
      .out_v_o         (out_v_o),
      .out_ready_and_i (out_ready_and_i),
      .out_first_o     (out_first_o),
      .out_last_o      (out_last_o)
   );

   typedef struct {
      logic [3:0]  mtype;
      logic [2:0]  size;
      logic [39:0] addr;
      bit          dead;
      int          n;
      int          idx0;
      int          mb;
      bit          fixed;
      logic [63:0] fdata;
   } vec_t;

   vec_t vecs[7];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [63:0] beat_word(input int tag, input int i);
      return {16'hDA7A, 8'(tag), 32'h0, 8'(i)};
   endfunction

   function automatic logic [511:0] block_of(input int tag);
      logic [511:0] b;
      for (int i = 0; i < 8; i++) b[i*64 +: 64] = beat_word(tag, i);
      return b;
   endfunction

   function automatic logic [127:0] hdr_of(input int tag, input logic [39:0] a);
      return {64'hC0DE, 16'h0, 8'(tag), a};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_msg(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a,
                           input logic [511:0] d, input logic [127:0] h);
      @(negedge clk);
      in_msg_type_i = t;
      in_size_i     = sz;
      in_addr_i     = a;
      in_data_i     = d;
      in_header_i   = h;
      in_v_i        = 1'b1;
      #1 chk("in_ready_idle", 128'(in_ready_and_o), 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_v_i = 1'b0;
   endtask

   task automatic expect_msg(input int n, input int idx0, input int mb, input logic [39:0] a,
                             input bit fixed, input logic [63:0] fdata, input int tag,
                             input logic [127:0] h);
      logic [39:0] m;
      logic [39:0] ea;
      logic [63:0] ed;
      m = 40'(mb - 1);
      for (int k = 0; k < n; k++) begin
         ea = (a & ~m) | ((a + 40'(8 * k)) & m);
         ed = fixed ? fdata : beat_word(tag, (idx0 + k) % n);
         #1;
         chk("beat_v",     128'(out_v_o),     128'd1);
         chk("beat_first", 128'(out_first_o), 128'(k == 0));
         chk("beat_last",  128'(out_last_o),  128'(k == n - 1));
         chk("beat_addr",  128'(out_addr_o),  128'(ea));
         chk("beat_data",  128'(out_data_o),  128'(ed));
         chk("beat_hdr",   out_header_o,      h);
         @(posedge clk);
         @(negedge clk);
      end
      #1 chk("idle_after_msg", 128'(out_v_o), 128'd0);
   endtask

   initial begin
      logic [511:0] d;
      int           k;
      int           cycles;

      vecs[0] = '{e_mem_msg_wr,    3'd6, 40'h1000, 1'b0, 8, 0, 64, 1'b0, 64'h0};
      vecs[1] = '{e_mem_msg_wr,    3'd6, 40'h1018, 1'b0, 8, 3, 64, 1'b0, 64'h0};
      vecs[2] = '{e_mem_msg_rd,    3'd6, 40'h2000, 1'b0, 1, 0, 64, 1'b1, 64'h0};
      vecs[3] = '{e_mem_msg_uc_wr, 3'd2, 40'h3004, 1'b1, 1, 0, 4,  1'b1, 64'hDEADBEEF_DEADBEEF};
      vecs[4] = '{e_mem_msg_wr,    3'd4, 40'h4008, 1'b0, 2, 1, 16, 1'b0, 64'h0};
      vecs[5] = '{e_mem_msg_wr,    3'd3, 40'h5010, 1'b0, 1, 0, 8,  1'b1, 64'hDA7A0500_00000000};
      vecs[6] = '{e_mem_msg_uc_wr, 3'd7, 40'h6020, 1'b0, 8, 4, 64, 1'b0, 64'h0};

      reset_i         = 1'b1;
      in_header_i     = '0;
      in_msg_type_i   = '0;
      in_size_i       = '0;
      in_addr_i       = '0;
      in_data_i       = '0;
      in_v_i          = 1'b0;
      out_ready_and_i = 1'b1;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", 128'(in_ready_and_o), 128'd0);
      chk("rst_out_v",    128'(out_v_o),        128'd0);
      chk("rst_first",    128'(out_first_o),    128'd0);
      chk("rst_last",     128'(out_last_o),     128'd0);
      chk("rst_data",     128'(out_data_o),     128'd0);
      chk("rst_addr",     128'(out_addr_o),     128'd0);
      chk("rst_hdr",      out_header_o,         128'd0);
      reset_i = 1'b0;
      #1 chk("post_rst_in_ready", 128'(in_ready_and_o), 128'd1);

      // Table-driven single messages
      for (int v = 0; v < 7; v++) begin
         d = vecs[v].dead ? {448'h0, 32'h12345678, 32'hDEADBEEF} : block_of(v);
         send_msg(vecs[v].mtype, vecs[v].size, vecs[v].addr, d, hdr_of(v, vecs[v].addr));
         expect_msg(vecs[v].n, vecs[v].idx0, vecs[v].mb, vecs[v].addr, vecs[v].fixed,
                    vecs[v].fdata, v, hdr_of(v, vecs[v].addr));
      end

      // Back-to-back size-4 writes with no bubble between messages
      @(negedge clk);
      in_msg_type_i = e_mem_msg_wr; in_size_i = 3'd4; in_addr_i = 40'h7000;
      in_data_i = block_of(20); in_header_i = hdr_of(20, 40'h7000); in_v_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_addr_i = 40'h7108; in_data_i = block_of(21); in_header_i = hdr_of(21, 40'h7108);
      #1;
      chk("b2b_a0_data",  128'(out_data_o),     128'(64'hDA7A1400_00000000));
      chk("b2b_a0_addr",  128'(out_addr_o),     128'(40'h7000));
      chk("b2b_a0_first", 128'(out_first_o),    128'd1);
      chk("b2b_a0_ready", 128'(in_ready_and_o), 128'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("b2b_a1_data",  128'(out_data_o),     128'(64'hDA7A1400_00000001));
      chk("b2b_a1_addr",  128'(out_addr_o),     128'(40'h7008));
      chk("b2b_a1_last",  128'(out_last_o),     128'd1);
      chk("b2b_a1_ready", 128'(in_ready_and_o), 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_v_i = 1'b0;
      #1;
      chk("b2b_b0_v",     128'(out_v_o),     128'd1);
      chk("b2b_b0_data",  128'(out_data_o),  128'(64'hDA7A1500_00000001));
      chk("b2b_b0_addr",  128'(out_addr_o),  128'(40'h7108));
      chk("b2b_b0_first", 128'(out_first_o), 128'd1);
      chk("b2b_b0_hdr",   out_header_o,      hdr_of(21, 40'h7108));
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("b2b_b1_data", 128'(out_data_o), 128'(64'hDA7A1500_00000000));
      chk("b2b_b1_addr", 128'(out_addr_o), 128'(40'h7100));
      chk("b2b_b1_last", 128'(out_last_o), 128'd1);
      @(posedge clk);
      @(negedge clk);
      #1 chk("b2b_idle", 128'(out_v_o), 128'd0);

      // Random output stalls: each beat must hold until accepted
      send_msg(e_mem_msg_wr, 3'd6, 40'h1028, block_of(9), hdr_of(9, 40'h1028));
      k = 0;
      cycles = 0;
      while (k < 8 && cycles < 200) begin
         out_ready_and_i = 1'($urandom_range(0, 1));
         #1;
         chk("stall_v",     128'(out_v_o),     128'd1);
         chk("stall_data",  128'(out_data_o),  128'(beat_word(9, (5 + k) % 8)));
         chk("stall_addr",  128'(out_addr_o),  128'(40'h1000 + 40'(((40 + 8 * k) % 64))));
         chk("stall_first", 128'(out_first_o), 128'(k == 0));
         chk("stall_last",  128'(out_last_o),  128'(k == 7));
         if (out_ready_and_i) k++;
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      if (k < 8) chk("stall_timeout", 128'(k), 128'd8);
      out_ready_and_i = 1'b1;
      #1 chk("stall_idle", 128'(out_v_o), 128'd0);

      // Reset during beat 3 of 8 drops the message
      send_msg(e_mem_msg_wr, 3'd6, 40'h1000, block_of(10), hdr_of(10, 40'h1000));
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1 chk("mid_beat3_addr", 128'(out_addr_o), 128'(40'h1018));
      reset_i = 1'b1;
      #1 chk("mid_rst_ready", 128'(in_ready_and_o), 128'd0);
      @(posedge clk);
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk("mid_rst_v",     128'(out_v_o),        128'd0);
      chk("mid_rst_first", 128'(out_first_o),    128'd0);
      chk("mid_rst_last",  128'(out_last_o),     128'd0);
      chk("mid_rst_ready", 128'(in_ready_and_o), 128'd1);
      @(posedge clk);
      @(negedge clk);
      #1 chk("mid_rst_still_idle", 128'(out_v_o), 128'd0);
      send_msg(vecs[1].mtype, vecs[1].size, vecs[1].addr, block_of(11), hdr_of(11, vecs[1].addr));
      expect_msg(8, 3, 64, vecs[1].addr, 1'b0, 64'h0, 11, hdr_of(11, vecs[1].addr));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
